// File: rtl/bird_physics.sv
// rtl/bird_physics.sv - bird sprite physics: gravity, flap, ceiling clamp, floor crash, once per frame
module bird_physics #(
    parameter int SCREEN_H    = 480,
    parameter int BALL_X      = 160,
    parameter int BALL_SIZE   = 16,
    parameter int START_Y     = 232,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 8,
    parameter int MAX_FALL    = 10,
    parameter int DEAD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       btn_flap,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    output logic [9:0] ballX,
    output logic [9:0] ballY,
    output logic [1:0] game_state,
    output logic       crash
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DEAD = 2'b10
    } state_e;

    localparam int DCW = $clog2(DEAD_FRAMES + 1);

    localparam logic [9:0]         TICK_LINE = 10'(SCREEN_H);
    localparam logic [9:0]         Y_START   = 10'(START_Y);
    localparam logic [9:0]         Y_REST    = 10'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] Y_FLOOR   = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [7:0]  VEL_FLAP  = 8'(-FLAP_VEL);
    localparam logic signed [7:0]  VEL_GRAV  = 8'(GRAVITY);
    localparam logic signed [7:0]  VEL_MAX   = 8'(MAX_FALL);
    localparam logic [DCW-1:0]     DEAD_LIM  = DCW'(DEAD_FRAMES);

    state_e                state_q, state_d;
    logic                  sync1_q, sync2_q, sync3_q;
    logic                  flap_req_q, flap_req_d;
    logic [9:0]            v_prev_q;
    logic [9:0]            ball_y_q, ball_y_d;
    logic signed [7:0]     vel_q, vel_d;
    logic [DCW-1:0]        dead_cnt_q, dead_cnt_d;
    logic                  crash_q, crash_d;

    logic                  flap_edge;
    logic                  tick;
    logic                  flap_now;
    logic                  dead_done;
    logic signed [7:0]     vel_grav;
    logic signed [7:0]     vel_n;
    logic signed [11:0]    y_n;
    logic                  hit_ceiling;
    logic                  hit_floor;
    logic                  apply_physics;

    // The horizontal counter is not needed: updates key off the vertical counter only.
    logic unused_h;
    assign unused_h = ^h_counter;

    // Button synchroniser plus one extra stage for rising-edge detection, and frame-line history.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            v_prev_q <= '0;
        end else begin
            sync1_q  <= btn_flap;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            v_prev_q <= v_counter;
        end
    end

    // Edge, frame tick and the physics candidate for this frame.
    always_comb begin
        flap_edge   = sync2_q & ~sync3_q;
        tick        = (v_counter == TICK_LINE) && (v_prev_q != TICK_LINE);
        // An edge arriving in the tick cycle itself is honoured at that tick.
        flap_now    = flap_req_q | flap_edge;
        dead_done   = (dead_cnt_q >= DEAD_LIM);
        vel_grav    = vel_q + VEL_GRAV;
        if (flap_now) begin
            vel_n = VEL_FLAP;
        end else if (vel_grav > VEL_MAX) begin
            vel_n = VEL_MAX;
        end else begin
            vel_n = vel_grav;
        end
        y_n         = $signed({2'b00, ball_y_q}) + $signed({{4{vel_n[7]}}, vel_n});
        hit_ceiling = y_n[11];
        hit_floor   = !hit_ceiling && (y_n >= Y_FLOOR);
        // In IDLE the ball sits at START_Y with zero velocity, so the flap uses the same path.
        apply_physics = tick && ((state_q == S_PLAY) || ((state_q == S_IDLE) && flap_now));
    end

    // Game state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; transitions only happen on the frame tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (flap_now) begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (hit_floor) begin
                        state_d = S_DEAD;
                    end
                end
                S_DEAD: begin
                    if (dead_done && flap_now) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Position, velocity, flap request, lockout counter and crash pulse for the coming cycle.
    always_comb begin
        ball_y_d   = ball_y_q;
        vel_d      = vel_q;
        dead_cnt_d = dead_cnt_q;
        crash_d    = 1'b0;
        flap_req_d = flap_now;
        if (tick) begin
            // Every tick consumes or discards the pending flap.
            flap_req_d = 1'b0;
            if (apply_physics) begin
                if (hit_ceiling) begin
                    ball_y_d = '0;
                    vel_d    = '0;
                end else if (hit_floor) begin
                    ball_y_d   = Y_REST;
                    vel_d      = '0;
                    dead_cnt_d = '0;
                    crash_d    = 1'b1;
                end else begin
                    ball_y_d = y_n[9:0];
                    vel_d    = vel_n;
                end
            end else if (state_q == S_DEAD) begin
                if (!dead_done) begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end else if (flap_now) begin
                    ball_y_d   = Y_START;
                    vel_d      = '0;
                    dead_cnt_d = '0;
                end
            end else begin
                ball_y_d = Y_START;
                vel_d    = '0;
            end
        end
    end

    // Physics registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ball_y_q   <= Y_START;
            vel_q      <= '0;
            dead_cnt_q <= '0;
            crash_q    <= 1'b0;
            flap_req_q <= 1'b0;
        end else begin
            ball_y_q   <= ball_y_d;
            vel_q      <= vel_d;
            dead_cnt_q <= dead_cnt_d;
            crash_q    <= crash_d;
            flap_req_q <= flap_req_d;
        end
    end

    assign ballX      = 10'(BALL_X);
    assign ballY      = ball_y_q;
    assign game_state = state_q;
    assign crash      = crash_q;

endmodule

// File: tb/tb_bird_physics.sv
// tb/tb_bird_physics.sv - directed self-checking bench for bird_physics
module tb_bird_physics;

    logic       clk;
    logic       clr_n;
    logic       btn_flap;
    logic [9:0] h_counter;
    logic [9:0] v_counter;
    logic [9:0] ballX;
    logic [9:0] ballY;
    logic [1:0] game_state;
    logic       crash;

    int n_chk;
    int n_fail;
    int crash_cnt;

    bird_physics dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .btn_flap  (btn_flap),
        .h_counter (h_counter),
        .v_counter (v_counter),
        .ballX     (ballX),
        .ballY     (ballY),
        .game_state(game_state),
        .crash     (crash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        h_counter <= h_counter + 10'd1;
        if (crash === 1'b1) crash_cnt <= crash_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input bit skip);
        @(negedge clk) v_counter = 10'd479;
        repeat (3) @(negedge clk);
        v_counter = skip ? 10'd481 : 10'd480;
        repeat (4) @(negedge clk);
        v_counter = 10'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame(1'b0);
    endtask

    task automatic press();
        @(negedge clk) btn_flap = 1'b1;
        repeat (4) @(negedge clk);
        btn_flap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        crash_cnt = 0;
        h_counter = 10'd0;
        v_counter = 10'd0;
        btn_flap  = 1'b0;
        clr_n     = 1'b0;

        // reset with the button toggling
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) btn_flap = ~btn_flap;
        end
        btn_flap = 1'b0;
        @(negedge clk);
        chk("rst_ballY", int'(ballY), 232);
        chk("rst_ballX", int'(ballX), 160);
        chk("rst_state", int'(game_state), 0);
        chk("rst_crash", int'(crash), 0);
        clr_n = 1'b1;
        repeat (3) @(negedge clk);

        // idle tick without flap
        frame(1'b0);
        chk("idle_hold_y", int'(ballY), 232);
        chk("idle_hold_state", int'(game_state), 0);

        // pending flap lost on reset
        press();
        clr_n = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        frame(1'b0);
        chk("rst_flap_lost_state", int'(game_state), 0);
        chk("rst_flap_lost_y", int'(ballY), 232);

        // start and gravity
        press();
        frame(1'b0);
        chk("start_state", int'(game_state), 1);
        chk("start_y_tick1", int'(ballY), 224);
        frame(1'b0);
        chk("start_y_tick2", int'(ballY), 217);
        frames(8);
        chk("start_y_tick10", int'(ballY), 197);

        // skipped tick line: no update
        frame(1'b1);
        chk("skip_line_y", int'(ballY), 197);

        // terminal velocity
        frames(8);
        chk("fall_vel9_y", int'(ballY), 241);
        frame(1'b0);
        chk("fall_vel10_y", int'(ballY), 251);
        frame(1'b0);
        chk("fall_terminal_y", int'(ballY), 261);

        // repeated flaps up to the ceiling
        for (int k = 1; k <= 32; k++) begin
            press();
            frame(1'b0);
            chk("flap_climb_y", int'(ballY), 261 - 8 * k);
        end
        press();
        frame(1'b0);
        chk("ceiling_y", int'(ballY), 0);
        chk("ceiling_state", int'(game_state), 1);
        frame(1'b0);
        chk("ceiling_next_y", int'(ballY), 1);

        // descent to the exact floor boundary
        frames(9);
        chk("descent_y55", int'(ballY), 55);
        press();
        frame(1'b0);
        chk("descent_flap_y", int'(ballY), 47);
        frames(18);
        chk("descent_y74", int'(ballY), 74);
        frames(38);
        chk("floor_margin_y", int'(ballY), 454);
        chk("floor_margin_state", int'(game_state), 1);
        chk("floor_margin_crash", crash_cnt, 0);
        frame(1'b0);
        chk("floor_y", int'(ballY), 464);
        chk("floor_state", int'(game_state), 2);
        chk("floor_crash_pulses", crash_cnt, 1);

        // dead lockout
        for (int i = 0; i < 60; i++) begin
            if (i == 10 || i == 59) press();
            frame(1'b0);
            if (i == 10 || i == 59) begin
                chk("dead_locked_state", int'(game_state), 2);
                chk("dead_locked_y", int'(ballY), 464);
            end
        end
        frame(1'b0);
        chk("dead_no_flap_state", int'(game_state), 2);

        // held button: single flap respawns, no second flap
        @(negedge clk) btn_flap = 1'b1;
        repeat (20) @(negedge clk);
        frame(1'b0);
        chk("respawn_state", int'(game_state), 0);
        chk("respawn_y", int'(ballY), 232);
        frame(1'b0);
        chk("held_no_second_flap", int'(game_state), 0);
        repeat (956) @(negedge clk);
        btn_flap = 1'b0;
        repeat (4) @(negedge clk);
        frame(1'b0);
        chk("held_release_state", int'(game_state), 0);
        chk("held_release_y", int'(ballY), 232);

        // restart, then reset mid-frame
        press();
        frame(1'b0);
        chk("restart_y", int'(ballY), 224);
        chk("restart_state", int'(game_state), 1);
        @(negedge clk) v_counter = 10'd470;
        @(negedge clk) clr_n = 1'b0;
        @(negedge clk);
        chk("midframe_rst_y", int'(ballY), 232);
        chk("midframe_rst_state", int'(game_state), 0);
        clr_n = 1'b1;
        v_counter = 10'd0;
        repeat (3) @(negedge clk);
        chk("total_crash_pulses", crash_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
